imm_decode_stage: RTL and testbench

//   Decode-stage buffer feeding the execute stage. Accepts fetched instructions on a valid/ready

---
 rtl/imm_decode_pkg.sv | 39 +++
 rtl/imm_decode_stage_immed_gen.sv | 31 +++
 rtl/imm_decode_stage.sv | 130 +++++++++++++
 tb/tb_imm_decode_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_decode_pkg.sv
// ============================================================================
// imm_decode_pkg : shared types and opcode constants for the decode stage
// Revision 1.0
// ============================================================================
`default_nettype none

package imm_decode_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] immed;
    imm_sel_t    sel;
    logic        has_imm;
    logic        illegal;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/imm_decode_stage_immed_gen.sv
// ============================================================================
// ImmedGen : combinational RISC-V immediate extraction and sign extension
// Revision 1.0
// ============================================================================
`default_nettype none

module ImmedGen
  import imm_decode_pkg::*;
(
  input  logic [31:7] inst_i,
  input  logic [2:0]  sel_i,
  output logic [31:0] immed_o
);

  always_comb begin
    immed_o = '0;
    case (sel_i)
      IMM_I:   immed_o = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   immed_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   immed_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                          inst_i[11:8], 1'b0};
      IMM_J:   immed_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                          inst_i[30:21], 1'b0};
      IMM_U:   immed_o = {inst_i[31:12], 12'b0};
      default: immed_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_decode_stage.sv
// ============================================================================
// imm_decode_stage : opcode classification plus 2-entry buffer toward execute
// Revision 1.0
// ============================================================================
`default_nettype none

module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_inst,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_immed,
  output logic [2:0]           out_imm_sel,
  output logic                 out_has_imm,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t               mem_q [2];
  logic [1:0]           count_q, count_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [ILL_CNT_W-1:0] ill_count_q, ill_count_d;

  imm_sel_t    dec_sel;
  logic        dec_has_imm;
  logic        dec_illegal;
  logic [31:0] gen_immed;
  entry_t      new_entry;
  entry_t      head;
  logic        push, pop;

  always_comb begin
    dec_sel     = IMM_I;
    dec_has_imm = 1'b0;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS: dec_has_imm = 1'b1;
      OP_STORE:  begin dec_sel = IMM_S; dec_has_imm = 1'b1; end
      OP_BRANCH: begin dec_sel = IMM_B; dec_has_imm = 1'b1; end
      OP_JAL:    begin dec_sel = IMM_J; dec_has_imm = 1'b1; end
      OP_LUI, OP_AUIPC: begin dec_sel = IMM_U; dec_has_imm = 1'b1; end
      OP_REG:    dec_has_imm = 1'b0;
      default:   dec_illegal = 1'b1;
    endcase
  end

  ImmedGen u_immed_gen (
    .inst_i  (in_inst[31:7]),
    .sel_i   (dec_sel),
    .immed_o (gen_immed)
  );

  always_comb begin
    new_entry.inst    = in_inst;
    new_entry.pc      = in_pc;
    new_entry.immed   = dec_has_imm ? gen_immed : 32'd0;
    new_entry.sel     = dec_sel;
    new_entry.has_imm = dec_has_imm;
    new_entry.illegal = dec_illegal;
  end

  // in_ready looks only at the registered count so it never chains through out_ready
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ill_count_d = ill_count_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop) count_d = count_q + 2'd1;
      if (pop && !push) count_d = count_q - 2'd1;
      if (push && dec_illegal && (ill_count_q != {ILL_CNT_W{1'b1}}))
        ill_count_d = ill_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      ill_count_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= new_entry;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ill_count_q <= ill_count_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_inst    = head.inst;
  assign out_pc      = head.pc;
  assign out_immed   = head.immed;
  assign out_imm_sel = head.sel;
  assign out_has_imm = head.has_imm;
  assign out_illegal = head.illegal;
  assign ill_count   = ill_count_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// ============================================================================
// tb_imm_decode_stage : directed vectors checked against a queue-based model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc, out_immed;
  logic [2:0]  out_imm_sel;
  logic        out_has_imm, out_illegal;
  logic [15:0] ill_count;

  int checks = 0;
  int errors = 0;

  imm_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_immed(out_immed),
    .out_imm_sel(out_imm_sel), .out_has_imm(out_has_imm),
    .out_illegal(out_illegal), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] immed;
    logic [2:0]  sel;
    logic        has_imm;
    logic        illegal;
  } exp_t;

  exp_t        mq[$];
  logic [15:0] m_ill = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference decode: immediates built from field arithmetic on the whole word
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [31:0] hi;
    e.inst = ins; e.pc = pc; e.immed = 0; e.sel = 3'd0; e.has_imm = 1'b1; e.illegal = 1'b0;
    hi = ins[31] ? 32'hFFFF_F000 : 32'h0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: e.immed = 32'($signed(ins) >>> 20);
      7'h23: begin
        e.sel = 3'd1;
        e.immed = (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | ((ins >> 7) & 32'h1F);
      end
      7'h63: begin
        e.sel = 3'd2;
        e.immed = hi + (((ins >> 7) & 32'h1) * 2048) + (((ins >> 25) & 32'h3F) * 32)
                + (((ins >> 8) & 32'hF) * 2);
      end
      7'h6F: begin
        e.sel = 3'd3;
        e.immed = (ins[31] ? 32'hFFF0_0000 : 32'h0) + (((ins >> 12) & 32'hFF) << 12)
                + (((ins >> 20) & 32'h1) * 2048) + (((ins >> 21) & 32'h3FF) * 2);
      end
      7'h37, 7'h17: begin e.sel = 3'd4; e.immed = ins & 32'hFFFF_F000; end
      7'h33: e.has_imm = 1'b0;
      default: begin e.has_imm = 1'b0; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ill <= '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      automatic bit do_push = in_valid && (mq.size() != 2);
      automatic bit do_pop  = (mq.size() != 0) && out_ready;
      automatic exp_t e = model_decode(in_inst, in_pc);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        if (e.illegal && m_ill != 16'hFFFF) m_ill <= m_ill + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() != 2));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("ill_count", 32'(ill_count), 32'(m_ill));
      if (mq.size() != 0) begin
        chk("out_inst", out_inst, mq[0].inst);
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_immed", out_immed, mq[0].immed);
        chk("out_imm_sel", 32'(out_imm_sel), 32'(mq[0].sel));
        chk("out_has_imm", 32'(out_has_imm), 32'(mq[0].has_imm));
        chk("out_illegal", 32'(out_illegal), 32'(mq[0].illegal));
      end
    end
  end

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  logic [31:0] seq_inst [4] = '{32'h0011_2623, 32'hFE00_0EE3, 32'h0100_006F, 32'h1234_50B7};
  logic [31:0] seq_imm  [4] = '{32'h0000_000C, 32'hFFFF_FFFC, 32'h0000_0010, 32'h1234_5000};
  logic [2:0]  seq_sel  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", out_inst | out_pc | out_immed, 32'd0);
    chk("rst_ill_count", 32'(ill_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,-1 with execute stalled
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 32'h100;
    edge1(); in_valid = 1'b0;
    @(negedge clk);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_immed", out_immed, 32'hFFFF_FFFF);
    chk("addi_sel", 32'(out_imm_sel), 32'd0);
    out_ready = 1'b1;
    edge1();

    // back-to-back stream, one result per cycle
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = seq_inst[i]; in_pc = 32'h200 + 32'(i * 4);
      edge1(); in_valid = 1'b0;
      @(negedge clk);
      chk("seq_immed", out_immed, seq_imm[i]);
      chk("seq_sel", 32'(out_imm_sel), 32'(seq_sel[i]));
    end
    edge1();
    chk("seq_drained", 32'(out_valid), 32'd0);

    // backpressure: third instruction must wait
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0000_0033; in_pc = 32'h300; edge1();
    in_inst = 32'h0000_0013; in_pc = 32'h304; edge1();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    in_inst = 32'h0000_0037; in_pc = 32'h308; edge1(); edge1();
    chk("bp_head_held", out_pc, 32'h300);
    out_ready = 1'b1; edge1();
    chk("bp_second", out_pc, 32'h304);
    edge1(); in_valid = 1'b0;
    chk("bp_third", out_pc, 32'h308);
    edge1();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // flush while full with a push pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0000_0013; in_pc = 32'h400; edge1();
    in_pc = 32'h404; edge1();
    flush = 1'b1; in_inst = 32'h0000_007F; in_pc = 32'h408; edge1();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_ill", 32'(ill_count), 32'd0);

    // illegal opcodes and counter saturation
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = 32'h0000_007F; in_pc = 32'h500 + 32'(i * 4);
      edge1(); in_valid = 1'b0;
      @(negedge clk);
      chk("ill_flag", 32'(out_illegal), 32'd1);
    end
    chk("ill_three", 32'(ill_count), 32'd3);
    in_valid = 1'b1; in_inst = 32'h0000_007F;
    for (int i = 0; i < 65531; i++) @(posedge clk);
    #1; in_valid = 1'b0;
    chk("ill_fffe", 32'(ill_count), 32'h0000_FFFE);
    in_valid = 1'b1; edge1(); edge1(); edge1(); in_valid = 1'b0;
    chk("ill_sat", 32'(ill_count), 32'h0000_FFFF);
    edge1();

    // asynchronous reset with one entry buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0010_0093; in_pc = 32'h600; edge1();
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1; #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ill", 32'(ill_count), 32'd0);
    chk("arst_data", out_inst | out_pc, 32'd0);
    @(negedge clk); rst = 1'b0;

    in_valid = 1'b1; in_inst = 32'h0000_0033; in_pc = 32'h700; edge1();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_has_imm", 32'(out_has_imm), 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
